amm_rr_arbiter_2to1: RTL
========================

// Module: amm_rr_arbiter_2to1
// PURPOSE
// Two-master round-robin arbiter sharing one Avalon-MM slave port (bridge input of the AMM-to-AHB path).
// Grants one master at a time and holds the grant until the command is accepted (s_waitrequest low).
// Tracks outstanding reads in order and routes each s_readdatavalid back to the issuing master.
// Single clock domain: aclk; reset aresetn is asynchronous, active-low.
// PARAMETERS
// P_AW     32  address width
// P_DW     32  data width; byteenable width = P_DW/8
// P_MAX_RD 4   max outstanding reads (ID FIFO depth, power of 2, >=2)
// PORTS
// aclk             in   1        clock
// aresetn          in   1        async active-low reset
// mN_address       in   P_AW     master N (N=0,1) address
// mN_writedata     in   P_DW     master N write data
// mN_byteenable    in   P_DW/8   master N byte enables
// mN_write/mN_read in   1        master N command strobes (never both high)
// mN_readdata      out  P_DW     = s_readdata (broadcast)
// mN_readdatavalid out  1        read data for master N
// mN_waitrequest   out  1        stall to master N
// s_address/s_writedata/s_byteenable out  P_AW/P_DW/P_DW/8  muxed command
// s_write/s_read   out  1        muxed command strobes
// s_readdata       in   P_DW     read data from slave
// s_readdatavalid  in   1        read response strobe
// s_waitrequest    in   1        slave stall
// err_unexp_rdv    out  1        sticky: readdatavalid with no outstanding read
// BEHAVIOUR
// Reset (async, aresetn=0): gnt_vld=0, rr_ptr=0 (master 0 preferred), rd_cnt=0, FIFO ptrs 0,
//   err_unexp_rdv=0; all outputs settle to s_read=s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
// States: IDLE (gnt_vld=0), GRANT (gnt_vld=1, gnt_id holds 0/1).
// IDLE: reqN = mN_read|mN_write; eligibleN = reqN & ~(mN_read & rd_cnt==P_MAX_RD).
//   One eligible -> GRANT to it next cycle. Both -> GRANT to rr_ptr. None -> stay.
//   Grant latency: 1 cycle after request seen; no command is driven in IDLE.
// GRANT: s_* = granted master's signals (combinational mux); other master sees waitrequest=1.
//   m[gnt_id]_waitrequest = s_waitrequest.
//   Accept = (s_read|s_write) & ~s_waitrequest -> IDLE next cycle, rr_ptr <= ~gnt_id.
//   If granted master drops read&write (protocol violation) -> IDLE, rr_ptr unchanged, no command.
//   Back-to-back from same master: min 2 cycles per command (accept, IDLE, GRANT).
// Read tracking: on read accept push gnt_id into ID FIFO, rd_cnt+1.
//   On s_readdatavalid: pop FIFO head h, pulse mh_readdatavalid same cycle (combinational), rd_cnt-1.
//   Push and pop same cycle: rd_cnt unchanged, both pointers advance.
//   rd_cnt==P_MAX_RD: reads ineligible in IDLE; writes still granted.
//   s_readdatavalid with rd_cnt==0: no pop, no mN_readdatavalid, err_unexp_rdv<=1 until reset.
// Writes: no response tracked; do not touch FIFO.
// Pointers wrap modulo P_MAX_RD; rd_cnt width clog2(P_MAX_RD)+1.
// Reset mid-transfer: grant and outstanding IDs discarded; any later s_readdatavalid flags err.
// TESTING
// m0 write 0x100 data 0xA5A5A5A5 be 4'hF, s_waitrequest=0 -> s_write 1 cycle after req, m0_waitrequest low that cycle.
// m0,m1 reads same cycle, rr_ptr=0 -> m0 granted first, m1 next; rdv pulses hit m0 then m1 in order.
// m1 write with s_waitrequest high 3 cycles -> s_* stable, m0 req meanwhile stalled, m0 granted after accept.
// P_MAX_RD=4, m0 issues 5 reads, no rdv -> 5th stalls in IDLE; m1 write still granted; one rdv unblocks 5th.
// s_readdatavalid with rd_cnt=0 -> no mN_readdatavalid, err_unexp_rdv=1 sticky until aresetn low.
// Random 10000 mixed commands, both masters, random s_waitrequest and rdv delay -> data/ID order match scoreboard.

Source files
------------

// File: rtl/amm_rr_arbiter_2to1.sv
// rtl/amm_rr_arbiter_2to1.sv - two-master round-robin Avalon-MM arbiter with in-order read-response routing
module amm_rr_arbiter_2to1 #(
   parameter int P_AW     = 32,
   parameter int P_DW     = 32,
   parameter int P_MAX_RD = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [P_AW-1:0]     m0_address,
   input  logic [P_DW-1:0]     m0_writedata,
   input  logic [P_DW/8-1:0]   m0_byteenable,
   input  logic                m0_write,
   input  logic                m0_read,
   output logic [P_DW-1:0]     m0_readdata,
   output logic                m0_readdatavalid,
   output logic                m0_waitrequest,
   input  logic [P_AW-1:0]     m1_address,
   input  logic [P_DW-1:0]     m1_writedata,
   input  logic [P_DW/8-1:0]   m1_byteenable,
   input  logic                m1_write,
   input  logic                m1_read,
   output logic [P_DW-1:0]     m1_readdata,
   output logic                m1_readdatavalid,
   output logic                m1_waitrequest,
   output logic [P_AW-1:0]     s_address,
   output logic [P_DW-1:0]     s_writedata,
   output logic [P_DW/8-1:0]   s_byteenable,
   output logic                s_write,
   output logic                s_read,
   input  logic [P_DW-1:0]     s_readdata,
   input  logic                s_readdatavalid,
   input  logic                s_waitrequest,
   output logic                err_unexp_rdv
);
   localparam int PW = $clog2(P_MAX_RD);
   localparam logic [PW:0]   RD_MAX  = (PW+1)'(P_MAX_RD);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t               state_q;
   logic                 gnt_id_q;
   logic                 rr_ptr_q;
   logic                 err_q;
   logic [PW:0]          rd_cnt_q, rd_cnt_d;
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [P_MAX_RD-1:0]  id_fifo_q;

   logic gnt_vld, rd_full, elig0, elig1, gnt_req, push, pop, head;

   assign gnt_vld = (state_q == ST_GRANT);
   assign rd_full = (rd_cnt_q == RD_MAX);
   // a read is not granted while every response slot is already in flight
   assign elig0   = (m0_read | m0_write) & ~(m0_read & rd_full);
   assign elig1   = (m1_read | m1_write) & ~(m1_read & rd_full);

   assign s_address    = gnt_id_q ? m1_address    : m0_address;
   assign s_writedata  = gnt_id_q ? m1_writedata  : m0_writedata;
   assign s_byteenable = gnt_id_q ? m1_byteenable : m0_byteenable;
   assign s_write      = gnt_vld & (gnt_id_q ? m1_write : m0_write);
   assign s_read       = gnt_vld & (gnt_id_q ? m1_read  : m0_read);
   assign gnt_req      = s_read | s_write;

   assign m0_waitrequest = ~(gnt_vld & ~gnt_id_q) | s_waitrequest;
   assign m1_waitrequest = ~(gnt_vld &  gnt_id_q) | s_waitrequest;

   assign push = s_read & ~s_waitrequest;
   assign pop  = s_readdatavalid & (rd_cnt_q != '0);
   assign head = id_fifo_q[rd_ptr_q];

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = pop & ~head;
   assign m1_readdatavalid = pop &  head;
   assign err_unexp_rdv    = err_q;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      if (push && !pop)
         rd_cnt_d = rd_cnt_q + CNT_ONE;
      else if (pop && !push)
         rd_cnt_d = rd_cnt_q - CNT_ONE;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         gnt_id_q  <= 1'b0;
         rr_ptr_q  <= 1'b0;
         rd_cnt_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         id_fifo_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            if (elig0 | elig1) begin
               state_q  <= ST_GRANT;
               gnt_id_q <= (elig0 & elig1) ? rr_ptr_q : elig1;
            end
         end else begin
            // a master that withdraws its command loses the grant without moving the pointer
            if (!gnt_req) begin
               state_q <= ST_IDLE;
            end else if (!s_waitrequest) begin
               state_q  <= ST_IDLE;
               rr_ptr_q <= ~gnt_id_q;
            end
         end
         if (push) begin
            id_fifo_q[wr_ptr_q] <= gnt_id_q;
            wr_ptr_q            <= wr_ptr_q + PTR_ONE;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         rd_cnt_q <= rd_cnt_d;
         if (s_readdatavalid && rd_cnt_q == '0)
            err_q <= 1'b1;
      end
   end
endmodule
